// File: rtl/sale_terminal_if.sv
// Handshake bundle between the sale terminal sequencer (master) and the
// barcode lookup / basket controllers (slave).
interface sale_terminal_if #(
  parameter int PRODUCT_W = 4,
  parameter int QTY_W     = 4
) ();
  logic                 Lookup_Req;
  logic                 Lookup_Ack;
  logic                 Lookup_Valid;
  logic [PRODUCT_W-1:0] Lookup_ProductID;
  logic [PRODUCT_W-1:0] BasketProductNum;
  logic                 Basket_Busy;
  logic [PRODUCT_W-1:0] ProductID_out;
  logic [QTY_W-1:0]     ProductQuantity;
  logic                 Basket_Add;
  logic                 Basket_Remove;
  logic                 Basket_Clear;

  modport master (
    output Lookup_Req, ProductID_out, ProductQuantity,
           Basket_Add, Basket_Remove, Basket_Clear,
    input  Lookup_Ack, Lookup_Valid, Lookup_ProductID,
           Basket_Busy, BasketProductNum
  );

  modport slave (
    input  Lookup_Req, ProductID_out, ProductQuantity,
           Basket_Add, Basket_Remove, Basket_Clear,
    output Lookup_Ack, Lookup_Valid, Lookup_ProductID,
           Basket_Busy, BasketProductNum
  );
endinterface

// File: rtl/sale_terminal_fsm.sv
// Top-level sale terminal sequencer: barcode entry, grid selection, quantity, basket edit, end.
// Optional inactivity timeout is compiled in when SALE_FSM_TIMEOUT_EN is defined.
module sale_terminal_fsm #(
  parameter int NUM_KEYS        = 4,
  parameter int BARCODE_DIGITS  = 4,
  parameter int PRODUCT_W       = 4,
  parameter int NUM_PRODUCTS    = 12,
  parameter int GRID_COLS       = 4,
  parameter int QTY_W           = 4,
  parameter int ERR_HOLD_CYCLES = 50_000_000,
  parameter int TIMEOUT_CYCLES  = 500_000_000
) (
  input  logic                                 CLOCK_50,
  input  logic                                 RESET_N,
  input  logic [NUM_KEYS-1:0]                  KEY_En,
  input  logic                                 Select_En,
  input  logic                                 SW_Interactive,
  input  logic                                 SW_Edit,
  sale_terminal_if.master                      bus,
  output logic [2:0]                           State,
  output logic [4*BARCODE_DIGITS-1:0]          Barcode_Digits,
  output logic [$clog2(BARCODE_DIGITS+1)-1:0]  Barcode_Count,
  output logic [PRODUCT_W-1:0]                 Cursor,
  output logic                                 Shopping_Done,
  output logic                                 Error,
  output logic                                 Timeout
);
  localparam int DIG_W  = 4 * BARCODE_DIGITS;
  localparam int CNT_W  = $clog2(BARCODE_DIGITS + 1);
  localparam int KIDX_W = $clog2(NUM_KEYS);
  localparam int ERR_W  = (ERR_HOLD_CYCLES > 1) ? $clog2(ERR_HOLD_CYCLES) : 1;
  localparam int QMAX   = (1 << QTY_W) - 1;

  typedef enum logic [2:0] {
    S_START       = 3'd0,
    S_IDLE        = 3'd1,
    S_BARCODE     = 3'd2,
    S_INTERACTIVE = 3'd3,
    S_QUANTITY    = 3'd4,
    S_EDIT        = 3'd5,
    S_END         = 3'd6,
    S_ERROR       = 3'd7
  } state_t;

  state_t               r_state, r_state_next;
  logic [DIG_W-1:0]     r_digits, r_digits_next;
  logic [CNT_W-1:0]     r_count, r_count_next;
  logic                 r_req, r_req_next;
  logic [PRODUCT_W-1:0] r_cursor, r_cursor_next;
  logic [PRODUCT_W-1:0] r_pid, r_pid_next;
  logic [QTY_W-1:0]     r_qty, r_qty_next;
  logic                 r_add, r_add_next;
  logic                 r_remove, r_remove_next;
  logic                 r_clear, r_clear_next;
  logic                 r_done, r_done_next;
  logic                 r_error, r_error_next;
  logic                 r_pend, r_pend_next;
  logic [ERR_W-1:0]     r_err_cnt, r_err_cnt_next;

`ifdef SALE_FSM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]      r_to_cnt, r_to_cnt_next;
  logic                 r_timeout, r_timeout_next;
  logic                 w_to_run;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  logic                 w_key_valid;
  logic [KIDX_W-1:0]    w_key_idx;
  logic [3:0]           w_digit;
  logic [QTY_W-1:0]     w_qty;
  logic                 w_dir_ok;
  logic [PRODUCT_W:0]   w_down;
  logic [PRODUCT_W-1:0] w_grid_next;
  logic [PRODUCT_W-1:0] w_num_last;
  logic [PRODUCT_W-1:0] w_edit_cur;
  logic [PRODUCT_W-1:0] w_edit_move;

  // Key decode: only a single-hot pulse counts as a keypress.
  always_comb begin
    w_key_valid = $onehot(KEY_En);
    w_key_idx   = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (KEY_En[k]) w_key_idx = KIDX_W'(k);
    end
    w_digit  = 4'(NUM_KEYS - int'(w_key_idx));
    if (int'(w_key_idx) + 1 > QMAX) w_qty = QTY_W'(QMAX);
    else                            w_qty = QTY_W'(int'(w_key_idx) + 1);
    w_dir_ok = w_key_valid && (int'(w_key_idx) < 4);
  end

  // Grid cursor: right/left wrap around the product list, up/down stop at the grid edge.
  always_comb begin
    w_grid_next = r_cursor;
    w_down      = {1'b0, r_cursor} + (PRODUCT_W+1)'(GRID_COLS);
    if (w_dir_ok) begin
      case (int'(w_key_idx))
        0: w_grid_next = (r_cursor == PRODUCT_W'(NUM_PRODUCTS - 1)) ? '0
                                                                    : r_cursor + PRODUCT_W'(1);
        1: if (w_down < (PRODUCT_W+1)'(NUM_PRODUCTS)) w_grid_next = w_down[PRODUCT_W-1:0];
        2: if (r_cursor >= PRODUCT_W'(GRID_COLS)) w_grid_next = r_cursor - PRODUCT_W'(GRID_COLS);
        3: w_grid_next = (r_cursor == '0) ? PRODUCT_W'(NUM_PRODUCTS - 1)
                                          : r_cursor - PRODUCT_W'(1);
        default: w_grid_next = r_cursor;
      endcase
    end
  end

  // Edit cursor is clamped to the live basket size before any move is applied.
  always_comb begin
    w_num_last = bus.BasketProductNum - PRODUCT_W'(1);
    if (bus.BasketProductNum == '0)  w_edit_cur = '0;
    else if (r_cursor > w_num_last)  w_edit_cur = w_num_last;
    else                             w_edit_cur = r_cursor;
    w_edit_move = w_edit_cur;
    if (w_dir_ok) begin
      case (int'(w_key_idx))
        0, 1: if (bus.BasketProductNum != '0 && w_edit_cur != w_num_last)
                w_edit_move = w_edit_cur + PRODUCT_W'(1);
        2, 3: if (w_edit_cur != '0) w_edit_move = w_edit_cur - PRODUCT_W'(1);
        default: w_edit_move = w_edit_cur;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= S_START;
      r_digits  <= '0;
      r_count   <= '0;
      r_req     <= 1'b0;
      r_cursor  <= '0;
      r_pid     <= '0;
      r_qty     <= '0;
      r_add     <= 1'b0;
      r_remove  <= 1'b0;
      r_clear   <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_pend    <= 1'b0;
      r_err_cnt <= '0;
`ifdef SALE_FSM_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state   <= r_state_next;
      r_digits  <= r_digits_next;
      r_count   <= r_count_next;
      r_req     <= r_req_next;
      r_cursor  <= r_cursor_next;
      r_pid     <= r_pid_next;
      r_qty     <= r_qty_next;
      r_add     <= r_add_next;
      r_remove  <= r_remove_next;
      r_clear   <= r_clear_next;
      r_done    <= r_done_next;
      r_error   <= r_error_next;
      r_pend    <= r_pend_next;
      r_err_cnt <= r_err_cnt_next;
`ifdef SALE_FSM_TIMEOUT_EN
      r_to_cnt  <= r_to_cnt_next;
      r_timeout <= r_timeout_next;
`endif
    end
  end

  always_comb begin
    r_state_next   = r_state;
    r_digits_next  = r_digits;
    r_count_next   = r_count;
    r_req_next     = r_req;
    r_cursor_next  = r_cursor;
    r_pid_next     = r_pid;
    r_qty_next     = r_qty;
    r_add_next     = 1'b0;
    r_remove_next  = 1'b0;
    r_clear_next   = 1'b0;
    r_done_next    = 1'b0;
    r_error_next   = r_error;
    r_pend_next    = r_pend;
    r_err_cnt_next = r_err_cnt;

    case (r_state)
      S_START: begin
        r_clear_next  = 1'b1;
        r_digits_next = '0;
        r_count_next  = '0;
        r_cursor_next = '0;
        r_qty_next    = '0;
        r_state_next  = S_IDLE;
      end

      S_IDLE: begin
        if (Select_En) begin
          r_state_next = S_END;
        end else if (SW_Edit) begin
          r_state_next  = S_EDIT;
          r_cursor_next = '0;
        end else if (SW_Interactive) begin
          r_state_next  = S_INTERACTIVE;
          r_cursor_next = '0;
        end else begin
          r_state_next = S_BARCODE;
        end
      end

      S_BARCODE: begin
        if (r_req) begin
          // Only the lookup answer matters while a request is outstanding.
          if (bus.Lookup_Ack) begin
            r_req_next    = 1'b0;
            r_digits_next = '0;
            r_count_next  = '0;
            if (bus.Lookup_Valid) begin
              r_pid_next   = bus.Lookup_ProductID;
              r_state_next = S_QUANTITY;
            end else begin
              r_state_next   = S_ERROR;
              r_error_next   = 1'b1;
              r_err_cnt_next = '0;
            end
          end
        end else if (SW_Interactive || SW_Edit) begin
          r_digits_next = '0;
          r_count_next  = '0;
          r_state_next  = S_IDLE;
        end else if (Select_En && r_count == CNT_W'(BARCODE_DIGITS)) begin
          r_req_next = 1'b1;
        end else if (w_key_valid && r_count != CNT_W'(BARCODE_DIGITS)) begin
          r_digits_next = (r_digits << 4) | DIG_W'(w_digit);
          r_count_next  = r_count + CNT_W'(1);
        end
      end

      S_INTERACTIVE: begin
        if (!SW_Interactive) begin
          r_state_next = S_IDLE;
        end else if (Select_En) begin
          r_pid_next   = r_cursor;
          r_state_next = S_QUANTITY;
        end else begin
          r_cursor_next = w_grid_next;
        end
      end

      S_QUANTITY: begin
        if (r_pend) begin
          if (!bus.Basket_Busy) begin
            r_add_next   = 1'b1;
            r_pend_next  = 1'b0;
            r_state_next = S_IDLE;
          end
        end else if (Select_En) begin
          r_state_next = S_IDLE;
        end else if (w_key_valid) begin
          r_qty_next = w_qty;
          if (bus.Basket_Busy) begin
            r_pend_next = 1'b1;
          end else begin
            r_add_next   = 1'b1;
            r_state_next = S_IDLE;
          end
        end
      end

      S_EDIT: begin
        r_cursor_next = w_edit_cur;
        if (r_pend) begin
          if (!bus.Basket_Busy) begin
            r_remove_next = 1'b1;
            r_pend_next   = 1'b0;
          end
        end else if (!SW_Edit) begin
          r_state_next = S_IDLE;
        end else if (Select_En) begin
          if (bus.BasketProductNum != '0) begin
            r_pid_next = w_edit_cur;
            if (bus.Basket_Busy) r_pend_next   = 1'b1;
            else                 r_remove_next = 1'b1;
          end
        end else begin
          r_cursor_next = w_edit_move;
        end
      end

      S_END: begin
        r_done_next  = 1'b1;
        r_state_next = S_START;
      end

      S_ERROR: begin
        if (r_err_cnt == ERR_W'(ERR_HOLD_CYCLES - 1)) begin
          r_error_next   = 1'b0;
          r_err_cnt_next = '0;
          r_state_next   = S_IDLE;
        end else begin
          r_err_cnt_next = r_err_cnt + ERR_W'(1);
        end
      end

      default: r_state_next = S_START;
    endcase

`ifdef SALE_FSM_TIMEOUT_EN
    r_to_cnt_next  = r_to_cnt;
    r_timeout_next = 1'b0;
    w_to_run = ((r_state == S_BARCODE) && (r_count != '0) && !r_req) ||
               (r_state == S_INTERACTIVE) ||
               ((r_state == S_QUANTITY) && !r_pend) ||
               (r_state == S_EDIT);
    if (r_state_next != r_state || w_key_valid || Select_En) begin
      r_to_cnt_next = '0;
    end else if (w_to_run) begin
      if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        r_to_cnt_next  = '0;
        r_timeout_next = 1'b1;
        r_digits_next  = '0;
        r_count_next   = '0;
        r_qty_next     = '0;
        r_pend_next    = 1'b0;
        r_state_next   = S_IDLE;
      end else begin
        r_to_cnt_next = r_to_cnt + TO_W'(1);
      end
    end
`endif
  end

  always_comb begin
    State               = r_state;
    Barcode_Digits      = r_digits;
    Barcode_Count       = r_count;
    Cursor              = r_cursor;
    Shopping_Done       = r_done;
    Error               = r_error;
    bus.Lookup_Req      = r_req;
    bus.ProductID_out   = r_pid;
    bus.ProductQuantity = r_qty;
    bus.Basket_Add      = r_add;
    bus.Basket_Remove   = r_remove;
    bus.Basket_Clear    = r_clear;
`ifdef SALE_FSM_TIMEOUT_EN
    Timeout             = r_timeout;
`else
    Timeout             = 1'b0;
`endif
  end

endmodule
